// File: rtl/inst_queue_pkg.sv
// Shared decode/issue types and queue sizing for the instruction queue.
// Stats feature (IQ_STAT_EN) lives in inst_queue.sv.
package Public_Info;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_PTR_W = $clog2(IQ_DEPTH);

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] inst;
    logic        o_valid;
  } PC_set;

  // Dispatch never takes more than two per cycle.
  function automatic logic [1:0] iq_clamp(
    input logic [1:0] n
  );
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/inst_queue_regfile.sv
// DEPTH x PC_set storage: two write ports, two combinational read ports.
// Contents are unreset; the queue masks stale entries with its valid bits.
module iq_regfile
  import Public_Info::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we0,
  input  logic [PW-1:0] i_wa0,
  input  PC_set         i_wd0,
  input  logic          i_we1,
  input  logic [PW-1:0] i_wa1,
  input  PC_set         i_wd1,
  input  logic [PW-1:0] i_ra0,
  input  logic [PW-1:0] i_ra1,
  output PC_set         o_rd0,
  output PC_set         o_rd1
);

  PC_set r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_wa0] <= i_wd0;
    if (i_we1) r_mem[i_wa1] <= i_wd1;
  end

  assign o_rd0 = r_mem[i_ra0];
  assign o_rd1 = r_mem[i_ra1];

endmodule

// File: rtl/inst_queue.sv
// Dual-write, dual-read in-order instruction queue between decode and issue.
// Define IQ_STAT_EN to add saturating empty/full cycle counters.
module inst_queue
  import Public_Info::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_flush,
  input  PC_set      i_set1,
  input  PC_set      i_set2,
  input  logic [1:0] i_valid,
  output logic       o_ready,
  output PC_set      o_set1,
  output PC_set      o_set2,
  output logic [1:0] o_is_valid,
  input  logic [1:0] i_usingNUM
`ifdef IQ_STAT_EN
  ,
  output logic [31:0] o_empty_cnt,
  output logic [31:0] o_full_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_free;
  logic [1:0]    w_push;
  logic [1:0]    w_req;
  logic [1:0]    w_pop;
  logic          w_we0;
  logic          w_we1;
  PC_set         w_wd0;
  PC_set         w_rd0;
  PC_set         w_rd1;

  assign w_free  = CW'(DEPTH) - r_count;
  assign o_ready = (w_free >= CW'(2));

  // Compact valid slots so the oldest lands at tail.
  always_comb begin
    w_push = 2'd0;
    if (o_ready) begin
      unique case (i_valid)
        2'b11:        w_push = 2'd2;
        2'b10, 2'b01: w_push = 2'd1;
        default:      w_push = 2'd0;
      endcase
    end
  end

  assign w_req = iq_clamp(i_usingNUM);
  assign w_pop = (CW'(w_req) > r_count) ? r_count[1:0] : w_req;

  assign w_we0 = (w_push != 2'd0) && !i_flush;
  assign w_we1 = (w_push == 2'd2) && !i_flush;
  assign w_wd0 = i_valid[1] ? i_set1 : i_set2;

  iq_regfile #(
    .DEPTH(DEPTH),
    .PW   (PW)
  ) u_rf (
    .clk  (clk),
    .i_we0(w_we0),
    .i_wa0(r_tail),
    .i_wd0(w_wd0),
    .i_we1(w_we1),
    .i_wa1(r_tail + PW'(1)),
    .i_wd1(i_set2),
    .i_ra0(r_head),
    .i_ra1(r_head + PW'(1)),
    .o_rd0(w_rd0),
    .o_rd1(w_rd1)
  );

  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_comb begin
    o_is_valid     = {r_count >= CW'(1), r_count >= CW'(2)};
    o_set1         = w_rd0;
    o_set1.o_valid = o_is_valid[1];
    o_set2         = w_rd1;
    o_set2.o_valid = o_is_valid[0];
  end

`ifdef IQ_STAT_EN
  logic [31:0] r_empty_cnt;
  logic [31:0] r_full_cnt;

  // Flush leaves the statistics alone; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_empty_cnt <= '0;
      r_full_cnt  <= '0;
    end else begin
      if (r_count == '0 && r_empty_cnt != '1)
        r_empty_cnt <= r_empty_cnt + 32'd1;
      if (!o_ready && r_full_cnt != '1)
        r_full_cnt <= r_full_cnt + 32'd1;
    end
  end

  assign o_empty_cnt = r_empty_cnt;
  assign o_full_cnt  = r_full_cnt;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: vector table plus PC scoreboard.
module tb_inst_queue;
  import Public_Info::*;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_flush;
  PC_set      i_set1;
  PC_set      i_set2;
  logic [1:0] i_valid;
  logic       o_ready;
  PC_set      o_set1;
  PC_set      o_set2;
  logic [1:0] o_is_valid;
  logic [1:0] i_usingNUM;
`ifdef IQ_STAT_EN
  logic [31:0] o_empty_cnt;
  logic [31:0] o_full_cnt;
`endif

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(D)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_flush   (i_flush),
    .i_set1    (i_set1),
    .i_set2    (i_set2),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_set1    (o_set1),
    .o_set2    (o_set2),
    .o_is_valid(o_is_valid),
    .i_usingNUM(i_usingNUM)
`ifdef IQ_STAT_EN
    ,
    .o_empty_cnt(o_empty_cnt),
    .o_full_cnt (o_full_cnt)
`endif
  );

  typedef struct {
    logic        flush;
    logic [1:0]  valid;
    logic [1:0]  usen;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic [1:0]  exp_v;
    logic        exp_rdy;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mq[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic [1:0] v,
                     input logic [1:0] u, input logic [1:0] ev,
                     input logic er);
    vec_t t;
    int   k;
    k         = vecs.size();
    t.flush   = f;
    t.valid   = v;
    t.usen    = u;
    t.pc1     = 32'h1000_0000 + 32'(k * 16);
    t.pc2     = 32'h1000_0008 + 32'(k * 16);
    t.exp_v   = ev;
    t.exp_rdy = er;
    vecs.push_back(t);
  endtask

  // Reference queue: pop oldest, then append accepted slots in order.
  task automatic model(input logic f, input logic [1:0] v,
                       input logic [1:0] u, input logic [31:0] p1,
                       input logic [31:0] p2);
    int  n;
    bit  rdy;
    rdy = (D - mq.size()) >= 2;
    if (f) begin
      mq.delete();
    end else begin
      n = (u == 2'd3) ? 2 : int'(u);
      if (n > mq.size()) n = mq.size();
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (rdy) begin
        if (v[1]) mq.push_back(p1);
        if (v[0]) mq.push_back(p2);
      end
    end
  endtask

  task automatic compare_heads(input string tag);
    chk({tag, "_v1fld"}, 32'(o_set1.o_valid), 32'(o_is_valid[1]));
    chk({tag, "_v2fld"}, 32'(o_set2.o_valid), 32'(o_is_valid[0]));
    if (mq.size() >= 1) chk({tag, "_pc1"}, o_set1.PC, mq[0]);
    if (mq.size() >= 2) chk({tag, "_pc2"}, o_set2.PC, mq[1]);
  endtask

  task automatic run(input vec_t t, input int idx);
    string tag;
    tag        = $sformatf("v%0d", idx);
    i_flush    = t.flush;
    i_valid    = t.valid;
    i_usingNUM = t.usen;
    i_set1     = {t.pc1, ~t.pc1, 1'b1};
    i_set2     = {t.pc2, ~t.pc2, 1'b1};
    model(t.flush, t.valid, t.usen, t.pc1, t.pc2);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(o_is_valid), 32'(t.exp_v));
    chk({tag, "_ready"}, 32'(o_ready), 32'(t.exp_rdy));
    compare_heads(tag);
  endtask

  initial begin
    rstn       = 1'b0;
    i_flush    = 1'b0;
    i_valid    = 2'b00;
    i_usingNUM = 2'd0;
    i_set1     = '0;
    i_set2     = '0;

    // Fill to 8, blocked push at full, flush with pushes pending.
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b11, 2'd0, 2'b11, 0);
    add(0, 2'b11, 2'd2, 2'b11, 1);
    add(0, 2'b00, 2'd1, 2'b11, 1);
    add(1, 2'b11, 2'd2, 2'b00, 1);
    // Lone set2 into empty, over-pop, empty pop, push-while-pop.
    add(0, 2'b01, 2'd0, 2'b10, 1);
    add(0, 2'b00, 2'd2, 2'b00, 1);
    add(0, 2'b00, 2'd3, 2'b00, 1);
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b11, 2'd2, 2'b11, 1);
    add(0, 2'b10, 2'd1, 2'b11, 1);
    add(0, 2'b00, 2'd3, 2'b00, 1);
    // Wrap: push 7 from index 6, pop 6, push 4, drain.
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b10, 2'd0, 2'b11, 0);
    add(0, 2'b11, 2'd2, 2'b11, 1);
    add(0, 2'b00, 2'd2, 2'b11, 1);
    add(0, 2'b00, 2'd2, 2'b10, 1);
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b11, 2'd0, 2'b11, 1);
    add(0, 2'b11, 2'd1, 2'b11, 1);
    add(0, 2'b11, 2'd2, 2'b11, 1);
    add(0, 2'b00, 2'd2, 2'b11, 1);
    add(0, 2'b00, 2'd2, 2'b11, 1);
    add(0, 2'b00, 2'd2, 2'b00, 1);
    vecs[7].pc2 = 32'h1c00_0010;

    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_valid", 32'(o_is_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);

    // Pushed entry must not show through before the clock edge.
    i_valid = 2'b11;
    i_set1  = {32'hdead_0000, 32'h0, 1'b1};
    i_set2  = {32'hdead_0004, 32'h0, 1'b1};
    #1;
    chk("same_cycle_valid", 32'(o_is_valid), 32'd0);
    i_valid = 2'b00;

    foreach (vecs[i]) run(vecs[i], i);

`ifdef IQ_STAT_EN
    begin
      logic [31:0] e0;
      e0 = o_empty_cnt;
      @(posedge clk);
      #1;
      chk("stat_empty_inc", o_empty_cnt, e0 + 32'd1);
    end
`endif

    // Reset mid-operation discards queued entries and pending pushes.
    begin
      vec_t t;
      t = '{flush: 0, valid: 2'b11, usen: 2'd0, pc1: 32'h2000_0000,
            pc2: 32'h2000_0004, exp_v: 2'b11, exp_rdy: 1};
      run(t, 100);
      rstn    = 1'b0;
      i_valid = 2'b11;
      @(posedge clk);
      #1;
      mq.delete();
      rstn = 1'b1;
      chk("midrst_valid", 32'(o_is_valid), 32'd0);
      chk("midrst_ready", 32'(o_ready), 32'd1);
      t = '{flush: 0, valid: 2'b10, usen: 2'd0, pc1: 32'h3000_0000,
            pc2: 32'h3000_0004, exp_v: 2'b10, exp_rdy: 1};
      run(t, 101);
    end

    i_valid    = 2'b00;
    i_usingNUM = 2'd0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
